// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Purpose:
//   Byte-stream-driven Wishbone initiator for debug and bring-up. Decodes
//   'W' (0x57) + 4 address + 4 data bytes, or 'R' (0x52) + 4 address bytes,
//   with multi-byte fields MSB first. It then runs one 32-bit classic cyc/ack
//   Wishbone cycle and returns a status byte, followed by 4 read-data bytes
//   for reads, on a valid/ready byte output.
//   Status bytes: 0x06 on ack, 0x15 on timeout (only with the timeout feature).
//
// Optional feature (macro WB_CMD_MASTER_TIMEOUT_EN):
//   When the macro is defined, a bus cycle is abandoned after TIMEOUT cycles
//   without ack. When it is undefined, BUS waits for ack forever.
//
// Parameters:
//   TIMEOUT      cycles to wait for ack before abandoning (1..65535)
//
// Ports:
//   wb_clk       clock, all logic on the rising edge
//   wb_rst       synchronous active-high reset
//   i_rx_data    command byte in
//   i_rx_valid   command byte valid
//   o_rx_ready   command byte accepted when valid & ready
//   o_tx_data    response byte out
//   o_tx_valid   response byte valid
//   i_tx_ready   response sink ready
//   o_wb_adr     bus address
//   o_wb_dat     bus write data
//   o_wb_sel     byte enables (4'hF during a cycle)
//   o_wb_we      1 = write
//   o_wb_cyc     bus cycle request
//   i_wb_rdt     bus read data
//   i_wb_ack     bus acknowledge
//   o_busy       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_busy
);

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] STAT_ACK    = 8'h06;
    localparam logic [7:0] STAT_TMO    = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_BUS  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_we;
    logic        r_long;    // response carries 4 data bytes after the status
    logic [39:0] r_tx_sh;   // status byte in [39:32], read data below it

    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_ack;
    logic        w_expire;
    logic        w_cnt_inc;

    assign o_rx_ready = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign o_tx_valid = (r_state == S_RESP);
    assign o_tx_data  = r_tx_sh[39:32];
    assign o_wb_cyc   = (r_state == S_BUS);
    assign o_wb_sel   = {4{o_wb_cyc}};
    assign o_wb_we    = r_we;
    assign o_wb_adr   = r_adr;
    assign o_wb_dat   = r_dat;
    assign o_busy     = (r_state != S_IDLE);

    assign w_rx_fire  = i_rx_valid && o_rx_ready;
    assign w_tx_fire  = o_tx_valid && i_tx_ready;
    // Ack only counts while a cycle is open; stale acks after cyc falls are ignored.
    assign w_ack      = i_wb_ack && (r_state == S_BUS);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // Expiry fires on the cycle the count would reach TIMEOUT, so cyc is high
    // for exactly TIMEOUT cycles; a simultaneous ack takes priority.
    assign w_expire = (r_state == S_BUS) && !i_wb_ack && (r_to_cnt == 16'(TIMEOUT - 1));

    // Timeout counter: zero outside BUS, counts BUS cycles without ack.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_to_cnt <= 16'd0;
        end else if (r_state != S_BUS) begin
            r_to_cnt <= 16'd0;
        end else if (!i_wb_ack) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^16'(TIMEOUT);
    assign w_expire         = 1'b0;
`endif

    // Next-state decode and byte-counter increment request.
    always_comb begin
        w_next    = r_state;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire && ((i_rx_data == CMD_WRITE) || (i_rx_data == CMD_READ))) begin
                    w_next = S_ADDR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ADDR: begin
                if (w_rx_fire) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == 3'd3) begin
                        w_next = r_we ? S_DATA : S_BUS;
                    end else begin
                        w_next = S_ADDR;
                    end
                end else begin
                    w_next = S_ADDR;
                end
            end
            S_DATA: begin
                if (w_rx_fire) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == 3'd3) begin
                        w_next = S_BUS;
                    end else begin
                        w_next = S_DATA;
                    end
                end else begin
                    w_next = S_DATA;
                end
            end
            S_BUS: begin
                if (w_ack || w_expire) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_BUS;
                end
            end
            S_RESP: begin
                if (w_tx_fire) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == (r_long ? 3'd4 : 3'd0)) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_RESP;
                    end
                end else begin
                    w_next = S_RESP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte counter: cleared on every state change, otherwise counts transfers.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_cnt <= 3'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 3'd0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Datapath: command capture, read-data latch and response shifter.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_adr   <= 32'd0;
            r_dat   <= 32'd0;
            r_we    <= 1'b0;
            r_long  <= 1'b0;
            r_tx_sh <= 40'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire && (i_rx_data == CMD_WRITE)) begin
                        r_we <= 1'b1;
                    end else if (w_rx_fire && (i_rx_data == CMD_READ)) begin
                        r_we <= 1'b0;
                    end else begin
                        r_we <= r_we;
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        r_adr <= {r_adr[23:0], i_rx_data};
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_dat <= {r_dat[23:0], i_rx_data};
                    end
                end
                S_BUS: begin
                    if (w_ack) begin
                        r_tx_sh <= {STAT_ACK, (r_we ? 32'd0 : i_wb_rdt)};
                        r_long  <= ~r_we;
                    end else if (w_expire) begin
                        r_tx_sh <= {STAT_TMO, 32'd0};
                        r_long  <= 1'b0;
                    end
                end
                S_RESP: begin
                    // Shift the next byte up on acceptance so it is presented without a bubble.
                    if (w_tx_fire) begin
                        r_tx_sh <= {r_tx_sh[31:0], 8'd0};
                    end
                end
                default: begin
                    r_tx_sh <= r_tx_sh;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

    localparam int TMO = 8;

    logic        wb_clk;
    logic        wb_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;
    logic        o_busy;

    wb_cmd_master #(.TIMEOUT(TMO)) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .o_busy     (o_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // responder controls and observations
    bit          resp_en      = 1'b1;
    int          resp_lat     = 0;
    bit          stale_mode   = 1'b0;
    bit          stale_pend   = 1'b0;
    int          wait_cnt     = 0;
    bit          rdt_fixed_en = 1'b0;
    logic [31:0] rdt_fixed    = 32'd0;
    logic [31:0] last_rdt     = 32'd0;

    int          txn_cnt = 0;
    int          cyc_len = 0;
    bit          prev_cyc = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Registered-ack responder with programmable latency and optional stale ack.
    initial begin
        i_wb_ack = 1'b0;
        i_wb_rdt = 32'd0;
        forever begin
            @(negedge wb_clk);
            if (i_wb_ack) begin
                if (stale_pend) stale_pend = 1'b0;
                else i_wb_ack = 1'b0;
            end else if (o_wb_cyc && resp_en) begin
                if (wait_cnt >= resp_lat) begin
                    i_wb_ack   = 1'b1;
                    i_wb_rdt   = rdt_fixed_en ? rdt_fixed : $urandom;
                    last_rdt   = i_wb_rdt;
                    stale_pend = stale_mode;
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Bus monitor: counts cycle starts and cycle length, captures request fields.
    initial begin
        forever begin
            @(negedge wb_clk);
            if (o_wb_cyc && !prev_cyc) begin
                txn_cnt++;
                cap_adr = o_wb_adr;
                cap_dat = o_wb_dat;
                cap_we  = o_wb_we;
                cap_sel = o_wb_sel;
            end
            if (o_wb_cyc) cyc_len++;
            prev_cyc = o_wb_cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge wb_clk);
        repeat ($urandom_range(0, 2)) @(negedge wb_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        k = 0;
        while (!o_rx_ready && k < 100) begin
            @(negedge wb_clk);
            k++;
        end
        check("rx_ready_wait", {63'd0, o_rx_ready}, 64'd1);
        @(posedge wb_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    // Collects n response bytes with random backpressure; bp forces ready low
    // for that many valid cycles first.
    task automatic collect(input int n, input int bp, output logic [7:0] got[$]);
        int   k;
        int   hold;
        bit   rdy;
        bit   prev_stall;
        bit   prev_acc;
        logic [7:0] prev_data;
        got        = {};
        k          = 0;
        hold       = bp;
        prev_stall = 1'b0;
        prev_acc   = 1'b0;
        prev_data  = 8'd0;
        while (got.size() < n && k < 400) begin
            @(negedge wb_clk);
            k++;
            if (prev_stall) check("tx_stable", {56'd0, o_tx_data}, {56'd0, prev_data});
            if (prev_acc) check("tx_no_bubble", {63'd0, o_tx_valid}, 64'd1);
            if (o_tx_valid && hold > 0) begin
                rdy = 1'b0;
                hold--;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            i_tx_ready = rdy;
            if (o_tx_valid && rdy) got.push_back(o_tx_data);
            prev_stall = o_tx_valid && !rdy;
            prev_acc   = o_tx_valid && rdy && (got.size() < n);
            prev_data  = o_tx_data;
        end
        @(negedge wb_clk);
        i_tx_ready = 1'b1;
        check("tx_count", 64'(got.size()), 64'(n));
        repeat (3) begin
            check("tx_after_resp", {63'd0, o_tx_valid}, 64'd0);
            @(negedge wb_clk);
        end
        check("busy_after_resp", {63'd0, o_busy}, 64'd0);
    endtask

    task automatic run_cmd(input bit is_wr, input logic [31:0] adr, input logic [31:0] dat,
                           input int n_garbage, input int lat, input bit stale, input int bp,
                           input bit expect_to);
        logic [7:0] b;
        logic [7:0] got[$];
        logic [7:0] exp[$];
        resp_en    = !expect_to;
        resp_lat   = lat;
        stale_mode = stale;
        txn_cnt    = 0;
        cyc_len    = 0;
        for (int g = 0; g < n_garbage; g++) begin
            b = 8'($urandom);
            while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
            send_byte(b);
        end
        if (n_garbage > 0) begin
            @(negedge wb_clk);
            check("garbage_no_tx", {63'd0, o_tx_valid}, 64'd0);
        end
        send_byte(is_wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
        if (is_wr) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
        @(negedge wb_clk);
        check("cyc_on_last_byte", {63'd0, o_wb_cyc}, 64'd1);
        check("rx_ready_in_bus", {63'd0, o_rx_ready}, 64'd0);
        collect(expect_to ? 1 : (is_wr ? 1 : 5), bp, got);
        if (expect_to) begin
            exp = {8'h15};
        end else if (is_wr) begin
            exp = {8'h06};
        end else begin
            exp = {8'h06, last_rdt[31:24], last_rdt[23:16], last_rdt[15:8], last_rdt[7:0]};
        end
        if (got.size() == exp.size()) begin
            for (int i = 0; i < exp.size(); i++) check("tx_byte", {56'd0, got[i]}, {56'd0, exp[i]});
        end
        check("txn_count", 64'(txn_cnt), 64'd1);
        check("wb_adr", {32'd0, cap_adr}, {32'd0, adr});
        check("wb_we", {63'd0, cap_we}, {63'd0, is_wr});
        check("wb_sel", {60'd0, cap_sel}, 64'hF);
        if (is_wr) check("wb_dat", {32'd0, cap_dat}, {32'd0, dat});
        check("cyc_len", 64'(cyc_len), expect_to ? 64'(TMO) : 64'(lat + 1));
        resp_en    = 1'b1;
        stale_mode = 1'b0;
    endtask

    initial begin
        logic [31:0] r_adr_v, r_dat_v;
        int k;
        wb_rst     = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'd0;
        i_tx_ready = 1'b0;
        repeat (3) @(negedge wb_clk);
        check("rst_cyc", {63'd0, o_wb_cyc}, 64'd0);
        check("rst_we", {63'd0, o_wb_we}, 64'd0);
        check("rst_sel", {60'd0, o_wb_sel}, 64'd0);
        check("rst_adr", {32'd0, o_wb_adr}, 64'd0);
        check("rst_dat", {32'd0, o_wb_dat}, 64'd0);
        check("rst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, o_tx_data}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        check("rx_ready_after_rst", {63'd0, o_rx_ready}, 64'd1);

        // directed: write, fixed-data read, garbage then read
        run_cmd(1'b1, 32'h4000_0000, 32'h0000_0001, 0, 0, 1'b0, 0, 1'b0);
        rdt_fixed_en = 1'b1;
        rdt_fixed    = 32'hDEAD_BEEF;
        run_cmd(1'b0, 32'h0000_0010, 32'd0, 0, 1, 1'b0, 0, 1'b0);
        check("read_rdt_fixed", {32'd0, last_rdt}, 64'hDEAD_BEEF);
        rdt_fixed_en = 1'b0;
        send_byte(8'h00);
        send_byte(8'hFF);
        @(negedge wb_clk);
        check("garbage_tx_valid", {63'd0, o_tx_valid}, 64'd0);
        check("garbage_busy", {63'd0, o_busy}, 64'd0);
        run_cmd(1'b0, 32'h8000_0000, 32'd0, 0, 0, 1'b0, 0, 1'b0);

        // backpressure 10 cycles with stale ack on the responder
        run_cmd(1'b0, 32'h1234_5678, 32'd0, 0, 1, 1'b1, 10, 1'b0);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        run_cmd(1'b0, 32'h3000_0000, 32'd0, 0, 0, 1'b0, 0, 1'b1);
        run_cmd(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 0, 2, 1'b0, 0, 1'b0);
        run_cmd(1'b0, 32'h3000_0008, 32'd0, 0, TMO - 1, 1'b0, 0, 1'b0);
`endif

        // reset while a cycle is open and no responder answers
        resp_en = 1'b0;
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h20);
        k = 0;
        while (!o_wb_cyc && k < 20) begin
            @(negedge wb_clk);
            k++;
        end
        check("cyc_before_rst", {63'd0, o_wb_cyc}, 64'd1);
        repeat (2) @(negedge wb_clk);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        check("midrst_cyc", {63'd0, o_wb_cyc}, 64'd0);
        check("midrst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
        check("midrst_busy", {63'd0, o_busy}, 64'd0);
        wb_rst  = 1'b0;
        resp_en = 1'b1;
        @(negedge wb_clk);
        check("midrst_rx_ready", {63'd0, o_rx_ready}, 64'd1);
        run_cmd(1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 0, 0, 1'b0, 0, 1'b0);

        // randomized commands
        for (int t = 0; t < 40; t++) begin
            r_adr_v = $urandom;
            r_dat_v = $urandom;
            run_cmd(1'($urandom_range(0, 1)), r_adr_v, r_dat_v, $urandom_range(0, 2),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
